// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQUEST, WAIT, DRAIN} fetch_state_t;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JUMP = 4'hF;
  localparam int OP_LSB   = 12;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_LSB = 4;
  localparam int TGT_LSB  = 0;
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] addr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: prefetch FIFO of {instruction, address} entries with flush
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int Depth = 2,
  localparam int AW = $clog2(Depth)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t head_o,
  output logic [AW:0]  count_o
);
  fetch_entry_t mem_q [Depth];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q;
  logic do_push, do_pop;
  assign do_pop  = pop_i && count_q != '0;
  assign do_push = push_i && (count_q != (AW+1)'(Depth) || do_pop);
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
  // pointers and occupancy; a flush empties the queue and wins over push/pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_q + AW'(do_push);
      rd_q    <= rd_q + AW'(do_pop);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage needs no reset: the head is only used while count is non-zero
  always_ff @(posedge clk)
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch FSM, fetch pointer and register-bank control decode
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int QueueDepth = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [15:0] redirect_address_i,
  output logic        mem_request_o,
  output logic [15:0] mem_address_o,
  input  logic        mem_grant_i,
  input  logic        mem_valid_i,
  input  logic [15:0] mem_data_i,
  output logic        instruction_valid_o,
  input  logic        instruction_ready_i,
  output logic [15:0] instruction_o,
  output logic [15:0] instruction_address_o,
  output logic [3:0]  source1_address_o,
  output logic [3:0]  source2_address_o,
  output logic [1:0]  target_address_o,
  output logic        target_write_enable_o,
  output logic        jump_o
);
  localparam int CW = $clog2(QueueDepth) + 1;
  fetch_state_t state_q, state_d;
  logic [15:0] fp_q, fp_d;
  logic [CW-1:0] count;
  fetch_entry_t head, push_data;
  logic push, pop;
  logic [3:0] opcode;
  assign instruction_valid_o = count != '0;
  assign pop  = instruction_valid_o && instruction_ready_i;
  assign push = state_q == WAIT && mem_valid_i && !redirect_i;
  // the pointer already advanced at grant, so the response belongs to fp - 2
  assign push_data = '{instr: mem_data_i, addr: fp_q - 16'd2};
  fetch_queue #(.Depth(QueueDepth)) u_queue (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(redirect_i),
    .data_i (push_data),
    .head_o (head),
    .count_o(count)
  );
  assign mem_request_o         = state_q == REQUEST;
  assign mem_address_o         = mem_request_o ? fp_q : 16'h0000;
  assign instruction_o         = instruction_valid_o ? head.instr : 16'h0000;
  assign instruction_address_o = instruction_valid_o ? head.addr : 16'h0000;
  assign opcode                = instruction_o[OP_LSB +: 4];
  assign source1_address_o     = instruction_o[SRC1_LSB +: 4];
  assign source2_address_o     = instruction_o[SRC2_LSB +: 4];
  assign target_address_o      = instruction_o[TGT_LSB +: 2];
  assign jump_o                = opcode == OP_JUMP;
  assign target_write_enable_o = opcode != OP_NOP && opcode != OP_JUMP;
  // state and fetch pointer registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      fp_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      fp_q    <= fp_d;
    end
  // next state and pointer; redirect outranks every other event in its cycle
  always_comb begin
    state_d = state_q;
    fp_d    = redirect_i ? {redirect_address_i[15:1], 1'b0} :
              (state_q == REQUEST && mem_grant_i) ? fp_q + 16'd2 : fp_q;
    case (state_q)
      IDLE:    state_d = (!redirect_i && int'(count) < QueueDepth) ? REQUEST : IDLE;
      REQUEST: state_d = mem_grant_i ? (redirect_i ? DRAIN : WAIT) : (redirect_i ? IDLE : REQUEST);
      WAIT:    state_d = redirect_i ? (mem_valid_i ? IDLE : DRAIN) :
                         !mem_valid_i ? WAIT :
                         (int'(count) + 1 - int'(pop) < QueueDepth) ? REQUEST : IDLE;
      DRAIN:   state_d = mem_valid_i ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed self-checking bench for instruction_fetch
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_address = 16'h0000;
  logic        mem_request;
  logic [15:0] mem_address;
  logic        mem_grant = 1'b0;
  logic        mem_valid = 1'b0;
  logic [15:0] mem_data = 16'h0000;
  logic        instruction_valid;
  logic        instruction_ready = 1'b0;
  logic [15:0] instruction;
  logic [15:0] instruction_address;
  logic [3:0]  source1_address;
  logic [3:0]  source2_address;
  logic [1:0]  target_address;
  logic        target_write_enable;
  logic        jump;
  int n_cmp = 0;
  int n_err = 0;

  instruction_fetch #(.QueueDepth(2)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .redirect_i           (redirect),
    .redirect_address_i   (redirect_address),
    .mem_request_o        (mem_request),
    .mem_address_o        (mem_address),
    .mem_grant_i          (mem_grant),
    .mem_valid_i          (mem_valid),
    .mem_data_i           (mem_data),
    .instruction_valid_o  (instruction_valid),
    .instruction_ready_i  (instruction_ready),
    .instruction_o        (instruction),
    .instruction_address_o(instruction_address),
    .source1_address_o    (source1_address),
    .source2_address_o    (source2_address),
    .target_address_o     (target_address),
    .target_write_enable_o(target_write_enable),
    .jump_o               (jump)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_req(input string tag, input logic req, input logic [15:0] addr);
    check({tag, ".req"}, {15'd0, mem_request}, {15'd0, req});
    check({tag, ".addr"}, mem_address, addr);
  endtask

  task automatic check_head(input string tag, input logic v, input logic [15:0] ins, input logic [15:0] ia,
                            input logic [3:0] s1, input logic [3:0] s2, input logic [1:0] t,
                            input logic we, input logic j);
    check({tag, ".valid"}, {15'd0, instruction_valid}, {15'd0, v});
    check({tag, ".instr"}, instruction, ins);
    check({tag, ".iaddr"}, instruction_address, ia);
    check({tag, ".src1"}, {12'd0, source1_address}, {12'd0, s1});
    check({tag, ".src2"}, {12'd0, source2_address}, {12'd0, s2});
    check({tag, ".tgt"}, {14'd0, target_address}, {14'd0, t});
    check({tag, ".twe"}, {15'd0, target_write_enable}, {15'd0, we});
    check({tag, ".jump"}, {15'd0, jump}, {15'd0, j});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check_req("reset", 1'b0, 16'h0000);
    check_head("reset", 1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    rst_n = 1'b1;
    mem_grant = 1'b1;
    tick();
    check_req("first_req", 1'b1, 16'h0000);
    tick();
    check_req("granted0", 1'b0, 16'h0000);
    mem_valid = 1'b1;
    mem_data  = 16'h1234;
    tick();
    check_head("head1234", 1'b1, 16'h1234, 16'h0000, 4'h2, 4'h3, 2'd0, 1'b1, 1'b0);
    check_req("second_req", 1'b1, 16'h0002);
    mem_valid = 1'b0;
    tick();
    check_req("granted2", 1'b0, 16'h0000);
    mem_valid = 1'b1;
    mem_data  = 16'hF000;
    tick();
    mem_valid = 1'b0;
    check_req("full0", 1'b0, 16'h0000);
    check_head("full_head", 1'b1, 16'h1234, 16'h0000, 4'h2, 4'h3, 2'd0, 1'b1, 1'b0);
    tick();
    check_req("full1", 1'b0, 16'h0000);
    tick();
    check_req("full2", 1'b0, 16'h0000);
    instruction_ready = 1'b1;
    tick();
    instruction_ready = 1'b0;
    check_head("headF000", 1'b1, 16'hF000, 16'h0002, 4'h0, 4'h0, 2'd0, 1'b0, 1'b1);
    mem_grant = 1'b0;
    tick();
    check_req("resume", 1'b1, 16'h0004);
    tick();
    check_req("stall1", 1'b1, 16'h0004);
    tick();
    check_req("stall2", 1'b1, 16'h0004);
    tick();
    check_req("stall3", 1'b1, 16'h0004);
    mem_grant = 1'b1;
    tick();
    mem_grant = 1'b0;
    check_req("grant_once", 1'b0, 16'h0000);
    redirect         = 1'b1;
    redirect_address = 16'h0101;
    tick();
    redirect = 1'b0;
    check_head("flushed", 1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    check_req("drain", 1'b0, 16'h0000);
    mem_valid = 1'b1;
    mem_data  = 16'hABCD;
    tick();
    mem_valid = 1'b0;
    check_head("late_discard", 1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    tick();
    check_req("redir_req", 1'b1, 16'h0100);
    mem_grant = 1'b1;
    tick();
    mem_grant = 1'b0;
    mem_valid = 1'b1;
    mem_data  = 16'h0000;
    tick();
    mem_valid = 1'b0;
    check_head("head0000", 1'b1, 16'h0000, 16'h0100, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    check_req("after_nop", 1'b1, 16'h0102);
    redirect         = 1'b1;
    redirect_address = 16'hFFFF;
    tick();
    redirect = 1'b0;
    check_req("redir_idle", 1'b0, 16'h0000);
    tick();
    check_req("top_req", 1'b1, 16'hFFFE);
    mem_grant = 1'b1;
    tick();
    mem_grant = 1'b0;
    mem_valid = 1'b1;
    mem_data  = 16'h1234;
    tick();
    mem_valid = 1'b0;
    check_req("wrap_req", 1'b1, 16'h0000);
    check_head("wrap_head", 1'b1, 16'h1234, 16'hFFFE, 4'h2, 4'h3, 2'd0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_req("async_reset", 1'b0, 16'h0000);
    check_head("async_reset", 1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
